// File: rtl/apb_mem_slave_pkg.sv
// Package apb_pkg: shared types and constants for the APB memory slave.
//   apb_state_t  - handshake FSM states (IDLE, SETUP, WAIT, ACCESS)
//   APB_ADDR_W   - word address width
//   APB_DATA_W   - data width
//   APB_ID_ADDR  - address of the read-only ID word (not backed by RAM)
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 16;
    localparam logic [APB_ADDR_W-1:0] APB_ID_ADDR = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        WAIT   = 2'd2,
        ACCESS = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_sram_sp.sv
// apb_sram_sp: single-port synchronous RAM, read-first, registered read, no reset.
// Ports:
//   clk    in   1    clock
//   we     in   1    write enable
//   addr   in   AW   word address (shared by read and write)
//   wdata  in   DW   write data
//   rdata  out  DW   read data, registered (valid the cycle after addr is presented)
module apb_sram_sp #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB slave with a 255-word x 16-bit RAM and a read-only ID word
// at address 8'hFF. Inserts WAIT_CYCLES wait states before a one-cycle pready.
// Ports:
//   pclk     in   1   APB clock
//   preset   in   1   asynchronous active-high reset
//   psel     in   1   slave select
//   penable  in   1   access-phase strobe
//   pwrite   in   1   1 = write, 0 = read
//   paddr    in   8   word address
//   pw_data  in   16  write data
//   pready   out  1   transfer complete (registered, one cycle wide)
//   pr_data  out  16  read data (registered, updated only on read commit)
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int unsigned             WAIT_CYCLES = 2,
    parameter logic [APB_DATA_W-1:0]   ID_VALUE    = 16'h5A02
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pw_data,
    output logic                  pready,
    output logic [APB_DATA_W-1:0] pr_data
);

    localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

    apb_state_t            r_state;
    logic [3:0]            r_cnt;
    logic [APB_ADDR_W-1:0] r_addr;
    logic                  r_write;
    logic [APB_DATA_W-1:0] r_wdata;
    logic                  r_pready;
    logic [APB_DATA_W-1:0] r_prdata;

    logic                  w_commit;
    logic                  w_ram_we;
    logic [APB_ADDR_W-1:0] w_ram_addr;
    logic [APB_DATA_W-1:0] w_ram_rdata;

    // The transfer completes on the edge that moves SETUP/WAIT into ACCESS.
    assign w_commit = psel && penable && (r_cnt == 4'd0) &&
                      ((r_state == SETUP) || (r_state == WAIT));

    // In IDLE the RAM is addressed straight from paddr so the registered read
    // data is already valid during SETUP; afterwards the latched address keeps
    // it valid for however long the transfer waits.
    assign w_ram_addr = (r_state == IDLE) ? paddr : r_addr;

    // The ID address is not backed by RAM; writes to it are discarded.
    assign w_ram_we = w_commit && r_write && (r_addr != APB_ID_ADDR);

    apb_sram_sp #(
        .AW (APB_ADDR_W),
        .DW (APB_DATA_W)
    ) u_sram (
        .clk   (pclk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_pready <= 1'b0;
            r_prdata <= '0;
        end else begin
            r_pready <= 1'b0;
            case (r_state)
                IDLE: begin
                    // psel with penable already high is a protocol violation: ignored.
                    if (psel && !penable) begin
                        r_state <= SETUP;
                        r_addr  <= paddr;
                        r_write <= pwrite;
                        r_wdata <= pw_data;
                        r_cnt   <= C_WAIT;
                    end
                end
                SETUP: begin
                    if (!psel) begin
                        r_state <= IDLE;
                    end else if (penable) begin
                        if (r_cnt == 4'd0) begin
                            r_state <= ACCESS;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= r_cnt - 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (!psel || !penable) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_commit) begin
                r_pready <= 1'b1;
                if (!r_write) begin
                    r_prdata <= (r_addr == APB_ID_ADDR) ? ID_VALUE : w_ram_rdata;
                end
            end
        end
    end

    assign pready  = r_pready;
    assign pr_data = r_prdata;

endmodule
